// File: rtl/fpu_issue_sequencer.sv
// Request-side sequencer for the FP ALU datapath: resolves rounding mode,
// screens NaN operands, issues to the datapath and returns the rounded result.
module fpu_issue_sequencer #(
    parameter int unsigned LATENCY         = 2,
    parameter logic [31:0] NAN_BYPASS_MASK = 32'h0000_000F,
    parameter logic [31:0] CANON_NAN       = 32'h7FC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic [31:0] req_conv,
    input  logic [2:0]  req_rm,
    input  logic [2:0]  frm,
    output logic [31:0] alu_rs1,
    output logic [31:0] alu_rs2,
    output logic [31:0] alu_conv,
    output logic [4:0]  alu_op,
    output logic [2:0]  alu_rm,
    output logic        alu_issue,
    input  logic [31:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_flags
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [3:0] LAT4 = 4'(LATENCY);

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_alu_rs1;
    logic [31:0] r_alu_rs2;
    logic [31:0] r_alu_conv;
    logic [4:0]  r_alu_op;
    logic [2:0]  r_alu_rm;
    logic [31:0] r_rsp_data;
    logic [1:0]  r_rsp_flags;

    logic        w_accept;
    logic [2:0]  w_eff_rm;
    logic        w_rm_illegal;
    logic        w_rs1_nan;
    logic        w_rs2_nan;
    logic        w_rs1_snan;
    logic        w_rs2_snan;
    logic        w_nan_bypass;
    logic        w_cnt_done;

    assign w_accept     = req_valid & req_ready;
    assign w_eff_rm     = (req_rm == 3'b111) ? frm : req_rm;
    // Modes 101, 110 and 111 have no defined rounding behaviour.
    assign w_rm_illegal = w_eff_rm[2] & (w_eff_rm[1] | w_eff_rm[0]);

    assign w_rs1_nan    = (&req_rs1[30:23]) & (|req_rs1[22:0]);
    assign w_rs2_nan    = (&req_rs2[30:23]) & (|req_rs2[22:0]);
    assign w_rs1_snan   = w_rs1_nan & ~req_rs1[22];
    assign w_rs2_snan   = w_rs2_nan & ~req_rs2[22];
    assign w_nan_bypass = NAN_BYPASS_MASK[req_op] & (w_rs1_nan | w_rs2_nan);

    assign w_cnt_done   = (r_cnt == LAT4);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = (w_rm_illegal | w_nan_bypass) ? RESP : ISSUE;
                end
            end
            ISSUE: w_next_state = WAIT;
            WAIT: begin
                if (w_cnt_done) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // req_ready is masked by rst so nothing is accepted during the reset cycle.
    always_comb begin
        req_ready = (r_state == IDLE) & ~rst;
        alu_issue = (r_state == ISSUE);
        rsp_valid = (r_state == RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_alu_rs1   <= '0;
            r_alu_rs2   <= '0;
            r_alu_conv  <= '0;
            r_alu_op    <= '0;
            r_alu_rm    <= '0;
            r_rsp_data  <= '0;
            r_rsp_flags <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        // Illegal rounding mode outranks the NaN screen.
                        if (w_rm_illegal) begin
                            r_rsp_data  <= '0;
                            r_rsp_flags <= 2'b10;
                        end else if (w_nan_bypass) begin
                            r_rsp_data  <= CANON_NAN;
                            r_rsp_flags <= {1'b0, w_rs1_snan | w_rs2_snan};
                        end else begin
                            r_alu_rs1   <= req_rs1;
                            r_alu_rs2   <= req_rs2;
                            r_alu_conv  <= req_conv;
                            r_alu_op    <= req_op;
                            r_alu_rm    <= w_eff_rm;
                        end
                    end
                end
                ISSUE: begin
                    r_cnt <= 4'd1;
                end
                WAIT: begin
                    r_cnt <= r_cnt + 4'd1;
                    if (w_cnt_done) begin
                        r_rsp_data  <= alu_result;
                        r_rsp_flags <= 2'b00;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign alu_rs1   = r_alu_rs1;
    assign alu_rs2   = r_alu_rs2;
    assign alu_conv  = r_alu_conv;
    assign alu_op    = r_alu_op;
    assign alu_rm    = r_alu_rm;
    assign rsp_data  = r_rsp_data;
    assign rsp_flags = r_rsp_flags;

endmodule

// File: tb/tb_fpu_issue_sequencer.sv
// Directed self-checking bench for fpu_issue_sequencer with a fixed-latency
// datapath model that only presents the real result in the sampling cycle.
module tb_fpu_issue_sequencer;

    localparam int LAT = 2;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_op;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic [31:0] req_conv;
    logic [2:0]  req_rm;
    logic [2:0]  frm;
    logic [31:0] alu_rs1;
    logic [31:0] alu_rs2;
    logic [31:0] alu_conv;
    logic [4:0]  alu_op;
    logic [2:0]  alu_rm;
    logic        alu_issue;
    logic [31:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_flags;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] modelResult = 32'h0;
    logic [31:0] lastRs1 = 32'h0;
    logic [LAT-1:0] issuePipe = '0;

    fpu_issue_sequencer #(
        .LATENCY(LAT),
        .NAN_BYPASS_MASK(32'h0000_000F),
        .CANON_NAN(32'h7FC0_0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op(req_op),
        .req_rs1(req_rs1),
        .req_rs2(req_rs2),
        .req_conv(req_conv),
        .req_rm(req_rm),
        .frm(frm),
        .alu_rs1(alu_rs1),
        .alu_rs2(alu_rs2),
        .alu_conv(alu_conv),
        .alu_op(alu_op),
        .alu_rm(alu_rm),
        .alu_issue(alu_issue),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data(rsp_data),
        .rsp_flags(rsp_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The datapath result is only correct LAT cycles after the issue cycle.
    always @(posedge clk) issuePipe <= {issuePipe[LAT-2:0], alu_issue};
    assign alu_result = issuePipe[LAT-1] ? modelResult : 32'hDEAD_BEEF;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b1;
        tick();
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_req_ready got %0b want 0", req_ready);
        end
        checks++;
        if ({rsp_valid, alu_issue, rsp_flags} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_ctrl got %b want 0000", {rsp_valid, alu_issue, rsp_flags});
        end
        checks++;
        if ({alu_rs1, alu_rs2, alu_conv, alu_op, alu_rm, rsp_data} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data got rs1=%h op=%h rm=%h data=%h want 0", alu_rs1, alu_op, alu_rm, rsp_data);
        end
        tick();
        checks++;
        if ({rsp_valid, alu_issue, req_ready} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_ignore_req got %b want 000", {rsp_valid, alu_issue, req_ready});
        end
        rst = 1'b0;
        req_valid = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL post_reset_ready got %0b want 1", req_ready);
        end
        lastRs1 = 32'h0;
    endtask

    task automatic run_normal(input string name, input logic [4:0] op, input logic [31:0] rs1,
                              input logic [31:0] rs2, input logic [31:0] conv, input logic [2:0] rm,
                              input logic [2:0] fr, input logic [2:0] expRm, input logic [31:0] result);
        modelResult = result;
        req_op = op; req_rs1 = rs1; req_rs2 = rs2; req_conv = conv; req_rm = rm; frm = fr;
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s ready_before got %0b want 1", name, req_ready);
        end
        tick();
        req_valid = 1'b0;
        checks++;
        if ({alu_issue, req_ready, rsp_valid} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL %s issue_cycle got issue/ready/valid=%b want 100", name, {alu_issue, req_ready, rsp_valid});
        end
        checks++;
        if ({alu_rs1, alu_rs2, alu_conv, alu_op, alu_rm} !== {rs1, rs2, conv, op, expRm}) begin
            errors++;
            $display("[TB] FAIL %s alu_fields got %h %h %h op=%h rm=%b want %h %h %h op=%h rm=%b",
                     name, alu_rs1, alu_rs2, alu_conv, alu_op, alu_rm, rs1, rs2, conv, op, expRm);
        end
        lastRs1 = rs1;
        for (int c = 2; c <= LAT + 1; c++) begin
            tick();
            checks++;
            if ({alu_issue, rsp_valid, req_ready} !== 3'b000) begin
                errors++;
                $display("[TB] FAIL %s wait_cycle%0d got issue/valid/ready=%b want 000", name, c, {alu_issue, rsp_valid, req_ready});
            end
        end
        tick();
        checks++;
        if ({rsp_valid, rsp_data, rsp_flags} !== {1'b1, result, 2'b00}) begin
            errors++;
            $display("[TB] FAIL %s response got valid=%0b data=%h flags=%b want 1 %h 00", name, rsp_valid, rsp_data, rsp_flags, result);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL %s after_handshake got valid/ready=%b want 01", name, {rsp_valid, req_ready});
        end
    endtask

    task automatic run_bypass(input string name, input logic [4:0] op, input logic [31:0] rs1,
                              input logic [31:0] rs2, input logic [2:0] rm, input logic [2:0] fr,
                              input logic [31:0] expData, input logic [1:0] expFlags);
        req_op = op; req_rs1 = rs1; req_rs2 = rs2; req_conv = 32'h1234_5678; req_rm = rm; frm = fr;
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        checks++;
        if ({rsp_valid, alu_issue, req_ready} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL %s bypass_ctrl got valid/issue/ready=%b want 100", name, {rsp_valid, alu_issue, req_ready});
        end
        checks++;
        if ({rsp_data, rsp_flags} !== {expData, expFlags}) begin
            errors++;
            $display("[TB] FAIL %s bypass_rsp got %h/%b want %h/%b", name, rsp_data, rsp_flags, expData, expFlags);
        end
        checks++;
        if (alu_rs1 !== lastRs1) begin
            errors++;
            $display("[TB] FAIL %s alu_rs1_hold got %h want %h", name, alu_rs1, lastRs1);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, req_ready, alu_issue} !== 3'b010) begin
            errors++;
            $display("[TB] FAIL %s bypass_after got valid/ready/issue=%b want 010", name, {rsp_valid, req_ready, alu_issue});
        end
    endtask

    task automatic test_basic();
        run_normal("basic", 5'd0, 32'h3F80_0000, 32'h4000_0000, 32'h0000_0000, 3'b000, 3'b000, 3'b000, 32'h4040_0000);
        run_normal("static_rm", 5'd3, 32'h4120_0000, 32'hC000_0000, 32'h0000_0007, 3'b100, 3'b001, 3'b100, 32'h40E0_0000);
    endtask

    task automatic test_dynamic_rm();
        run_normal("dyn_rm", 5'd2, 32'h4080_0000, 32'h3F00_0000, 32'h0000_0000, 3'b111, 3'b010, 3'b010, 32'h4100_0000);
    endtask

    task automatic test_illegal_rm();
        run_bypass("dyn_illegal", 5'd0, 32'h3F80_0000, 32'h4000_0000, 3'b111, 3'b110, 32'h0, 2'b10);
        run_bypass("static_illegal", 5'd9, 32'h3F80_0000, 32'h4000_0000, 3'b101, 3'b000, 32'h0, 2'b10);
        run_bypass("illegal_over_nan", 5'd1, 32'h7F80_0001, 32'h4000_0000, 3'b110, 3'b000, 32'h0, 2'b10);
    endtask

    task automatic test_nan();
        run_bypass("snan_rs1", 5'd1, 32'h7F80_0001, 32'h4000_0000, 3'b000, 3'b000, 32'h7FC0_0000, 2'b01);
        run_bypass("qnan_rs2", 5'd2, 32'h3F80_0000, 32'hFFC0_0001, 3'b001, 3'b000, 32'h7FC0_0000, 2'b00);
        run_normal("snan_unmasked", 5'd8, 32'h7F80_0001, 32'h4000_0000, 32'h0000_0000, 3'b000, 3'b000, 3'b000, 32'h1357_9BDF);
        run_normal("inf_not_nan", 5'd1, 32'h7F80_0000, 32'h4000_0000, 32'h0000_0000, 3'b011, 3'b000, 3'b011, 32'h7F80_0000);
    endtask

    task automatic test_back_to_back();
        run_normal("b2b_first", 5'd4, 32'h4040_0000, 32'h4040_0000, 32'h0, 3'b000, 3'b000, 3'b000, 32'h4110_0000);
        run_normal("b2b_second", 5'd5, 32'h4110_0000, 32'h3F80_0000, 32'h0, 3'b001, 3'b000, 3'b001, 32'h4120_0000);
    endtask

    task automatic test_backpressure();
        modelResult = 32'h4248_0000;
        req_op = 5'd6; req_rs1 = 32'h41C8_0000; req_rs2 = 32'h41C8_0000; req_conv = 32'h0;
        req_rm = 3'b000; frm = 3'b000;
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        tick();
        lastRs1 = 32'h41C8_0000;
        for (int c = 0; c < LAT + 1; c++) tick();
        // Keep a new request pending to make sure it is not accepted early.
        for (int c = 0; c < 10; c++) begin
            checks++;
            if ({rsp_valid, req_ready, rsp_data, rsp_flags} !== {1'b1, 1'b0, 32'h4248_0000, 2'b00}) begin
                errors++;
                $display("[TB] FAIL hold_cycle%0d got valid=%0b ready=%0b data=%h flags=%b want 1 0 42480000 00",
                         c, rsp_valid, req_ready, rsp_data, rsp_flags);
            end
            tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL no_turnaround got ready=%0b want 0", req_ready);
        end
        tick();
        rsp_ready = 1'b0;
        checks++;
        if ({req_ready, rsp_valid} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL release got ready/valid=%b want 10", {req_ready, rsp_valid});
        end
    endtask

    task automatic test_reset_in_wait();
        modelResult = 32'h0BAD_0BAD;
        req_op = 5'd0; req_rs1 = 32'h4000_0000; req_rs2 = 32'h4000_0000; req_conv = 32'h0;
        req_rm = 3'b000; frm = 3'b000;
        req_valid = 1'b1;
        rsp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({rsp_valid, alu_issue, req_ready} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL rst_wait_ctrl got valid/issue/ready=%b want 000", {rsp_valid, alu_issue, req_ready});
        end
        checks++;
        if ({alu_rs1, rsp_data} !== 64'h0) begin
            errors++;
            $display("[TB] FAIL rst_wait_data got rs1=%h data=%h want 0 0", alu_rs1, rsp_data);
        end
        rst = 1'b0;
        lastRs1 = 32'h0;
        for (int c = 0; c < LAT + 2; c++) begin
            tick();
            checks++;
            if ({rsp_valid, req_ready} !== 2'b01) begin
                errors++;
                $display("[TB] FAIL dropped_op_cycle%0d got valid/ready=%b want 01", c, {rsp_valid, req_ready});
            end
        end
        run_normal("after_reset", 5'd7, 32'hBF80_0000, 32'h3F80_0000, 32'h0000_00FF, 3'b111, 3'b011, 3'b011, 32'h8000_0000);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        req_op = '0; req_rs1 = '0; req_rs2 = '0; req_conv = '0;
        req_rm = '0; frm = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_basic();
        test_dynamic_rm();
        test_illegal_rm();
        test_nan();
        test_back_to_back();
        test_backpressure();
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpu_issue_sequencer.md
# fpu_issue_sequencer

Request-side sequencer for the floating-point ALU datapath (ALU plus normalize/round stage). Accepts one FP operation per handshake, resolves the rounding mode, pre-screens NaN operands, drives the operand, opcode and rounding-mode inputs of the datapath, and waits a fixed datapath latency. It then captures the rounded result and returns it to the requester over a valid/ready response channel.

## Interface
Parameters:
- LATENCY, 2, cycles from the `alu_issue` cycle to the cycle `alu_result` is valid; legal range 1..15.
- NAN_BYPASS_MASK, 32'h0000_000F, bit k set means opcode k returns canonical NaN without issuing when either operand is NaN.
- CANON_NAN, 32'h7FC0_0000, value returned on NaN bypass.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_op  in  5  datapath opcode.
- req_rs1  in  32  operand 1, IEEE-754 single.
- req_rs2  in  32  operand 2.
- req_conv  in  32  conversion operand.
- req_rm  in  3  instruction rounding mode; 3'b111 means dynamic.
- frm  in  3  dynamic rounding mode.
- alu_rs1  out  32  registered operand 1 to the datapath.
- alu_rs2  out  32  registered operand 2.
- alu_conv  out  32  registered conversion operand.
- alu_op  out  5  registered opcode.
- alu_rm  out  3  resolved rounding mode.
- alu_issue  out  1  one-cycle pulse marking the issue cycle.
- alu_result  in  32  rounded datapath result.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_data  out  32  result.
- rsp_flags  out  2  [1] illegal rounding mode; [0] invalid (signaling NaN operand).

## Operation
- FSM states are IDLE, ISSUE, WAIT and RESP. Reset state is IDLE.
- IDLE
  - `req_ready` is 1.
  - On `req_valid & req_ready`, latch all request fields and evaluate the checks below in priority order.
  - Go to RESP or ISSUE according to the checks.
- Rounding-mode resolution:
  - eff_rm = `frm` if `req_rm` == 3'b111, otherwise `req_rm`.
  - If eff_rm is 3'b101, 3'b110 or 3'b111: `rsp_data` = 0, `rsp_flags` = 2'b10, go directly to RESP with no issue.
- NaN screen (only when rm is legal and NAN_BYPASS_MASK[req_op] = 1):
  - An operand is NaN when exp == 8'hFF and mant != 0. It is sNaN when it is NaN and mant[22] == 0.
  - If either rs1 or rs2 is NaN: `rsp_data` = CANON_NAN, `rsp_flags`[0] = 1 if either operand is sNaN, `rsp_flags`[1] = 0, go to RESP with no issue.
- Otherwise go to ISSUE.
- ISSUE
  - `alu_*` registers hold the latched fields, with `alu_rm` = eff_rm.
  - `alu_issue` = 1 for this single cycle.
  - Load the 4-bit counter with 1 and go to WAIT.
- WAIT
  - The counter increments each cycle.
  - When the counter == LATENCY: capture `alu_result` into `rsp_data`, set `rsp_flags` = 0, go to RESP.
- RESP
  - `rsp_valid` is 1.
  - `rsp_data` and `rsp_flags` stay stable until `rsp_valid & rsp_ready`, then go to IDLE.
- Outside ISSUE/WAIT, the `alu_*` operand outputs hold their last values. `alu_issue` is 0.

## Timing
- Reset values:
  - `req_ready` = 0 during the reset cycle, 1 after it.
  - `rsp_valid` = 0, `alu_issue` = 0.
  - All `alu_*` data outputs = 0; `rsp_data` = 0; `rsp_flags` = 0; counter = 0.
- Normal path, request accepted at edge T:
  - `alu_issue` is high during cycle T+1.
  - `alu_result` is sampled at the edge ending cycle T+1+LATENCY.
  - `rsp_valid` rises in cycle T+2+LATENCY.
- Bypass path (illegal rm or NaN): `rsp_valid` rises in cycle T+1.
- Throughput is one request in flight; `req_ready` = 0 from the acceptance edge until the response handshake completes.
- On response handshake at edge R, `req_ready` = 1 in cycle R+1. There is no same-cycle response-to-request turnaround.
- If `rsp_ready` is held low, the FSM stays in RESP indefinitely with data stable.
- `rst` asserted in any state: at the next edge the FSM returns to IDLE, all outputs take reset values, and the in-flight operation is dropped.
- `req_valid` asserted during reset is ignored.

## Test plan
- Reset and rm=3'b000, op=0, rs1=32'h3F80_0000, rs2=32'h4000_0000, LATENCY=2, `alu_result` model returns 32'h4040_0000:
  - `alu_issue` is high exactly in cycle T+1.
  - `rsp_valid` rises in cycle T+4 with `rsp_data` = 32'h4040_0000 and flags 2'b00.
- req_rm=3'b111 with frm=3'b010: `alu_rm` = 3'b010.
- req_rm=3'b111 with frm=3'b110: no `alu_issue`; `rsp_valid` in cycle T+1 with data 0 and flags 2'b10.
- op=1, rs1=32'h7F80_0001 (sNaN):
  - Response is 32'h7FC0_0000 with flags 2'b01 in cycle T+1, with no issue.
  - Repeat with op=8 (mask bit clear): the operation issues normally and returns `alu_result`.
- Hold `rsp_ready` = 0 for 10 cycles: `rsp_data` stays stable and `req_ready` stays 0. Release `rsp_ready`: `req_ready` = 1 on the next cycle.
- Assert `rst` in WAIT: next cycle is IDLE with `rsp_valid` = 0. A later request completes correctly.
